// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// default widths, FSM encoding and the bit-counter width helper.
package bin2bcd_pkg;

  localparam int BIT_SZ_DEF = 16;
  localparam int DIGITS_DEF = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must hold the value BIT_SZ itself, hence +1.
  function automatic int cnt_width(input int bit_sz);
    return $clog2(bit_sz + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5..9 gets +3 before the
// shift so that the doubled value carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Add-3 correction, 4-bit wrap is safe because inputs never exceed 9.
  always_comb begin
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done
// handshake; one input bit is consumed per clock.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIT_SZ = BIT_SZ_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIT_SZ-1:0]     bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = cnt_width(BIT_SZ);
  localparam int SW = 4 * DIGITS;

  state_t            r_state;
  logic [BIT_SZ-1:0] r_shift;
  logic [SW-1:0]     r_scratch;
  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_bcd;
  logic              r_done;

  state_t            w_state_nxt;
  logic [BIT_SZ-1:0] w_shift_nxt;
  logic [SW-1:0]     w_scratch_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [SW-1:0]     w_bcd_nxt;
  logic              w_done_nxt;
  logic [SW-1:0]     w_adj;
  logic [SW-1:0]     w_scr_shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_scratch[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // Corrected scratch shifted left, pulling in the next binary MSB.
  assign w_scr_shifted = {w_adj[SW-2:0], r_shift[BIT_SZ-1]};

  // Next-state and datapath update for the IDLE/SHIFT controller.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_scratch_nxt = r_scratch;
    w_cnt_nxt     = r_cnt;
    w_bcd_nxt     = r_bcd;
    w_done_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_shift_nxt   = bin_in;
          w_scratch_nxt = {SW{1'b0}};
          w_cnt_nxt     = CW'(BIT_SZ);
          w_state_nxt   = SHIFT;
        end else begin
          w_state_nxt   = IDLE;
        end
      end
      SHIFT: begin
        w_shift_nxt   = {r_shift[BIT_SZ-2:0], 1'b0};
        w_scratch_nxt = w_scr_shifted;
        w_cnt_nxt     = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_bcd_nxt   = w_scr_shifted;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= {BIT_SZ{1'b0}};
      r_scratch <= {SW{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_bcd     <= {SW{1'b0}};
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_scratch <= w_scratch_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bcd     <= w_bcd_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign busy    = (r_state == SHIFT);
  assign done    = r_done;
  assign bcd_out = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expected BCD and
// completion cycle, a negedge monitor pops and compares on every done.
module tb_bin2bcd_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;

  typedef struct {
    logic [19:0] bcd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   cyc;

  bin2bcd_seq dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int          t;
    r = 20'h0;
    t = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset && done) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got done with bcd 0x%05h at cycle %0d, expected no done", bcd_out, cyc);
      end else begin
        e = sb.pop_front();
        check("bcd_value", 32'(bcd_out), 32'(e.bcd));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Wait for done with a bound, returning the number of busy cycles seen.
  task automatic wait_done(output int busy_n);
    bit seen;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout: got no done in 40 cycles, expected done");
    end
  endtask

  task automatic do_conv(input logic [15:0] v, input logic [19:0] exp_bcd);
    int bn;
    @(negedge clock);
    bin_in = v;
    start  = 1'b1;
    sb.push_back('{bcd: exp_bcd, cyc: cyc + 17});
    @(negedge clock);
    start  = 1'b0;
    bin_in = ~v;
    wait_done(bn);
    check("busy_cycles", 32'(bn), 32'd16);
    @(negedge clock);
    check("done_single_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int          bn;
    int          c0;
    logic [15:0] cnt16;
    logic [15:0] vec_in  [5];
    logic [19:0] vec_exp [5];

    vec_in[0] = 16'd0;     vec_exp[0] = 20'h00000;
    vec_in[1] = 16'hFFFF;  vec_exp[1] = 20'h65535;
    vec_in[2] = 16'd1234;  vec_exp[2] = 20'h01234;
    vec_in[3] = 16'd9;     vec_exp[3] = 20'h00009;
    vec_in[4] = 16'd10;    vec_exp[4] = 20'h00010;

    checks   = 0;
    failures = 0;
    cyc      = 0;
    reset    = 1'b0;
    start    = 1'b0;
    bin_in   = 16'h0;
    repeat (3) @(negedge clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd", 32'(bcd_out), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) do_conv(vec_in[i], vec_exp[i]);

    // Second request while busy must be dropped.
    @(negedge clock);
    c0     = cyc;
    bin_in = 16'd500;
    start  = 1'b1;
    sb.push_back('{bcd: 20'h00500, cyc: c0 + 17});
    @(negedge clock);
    start  = 1'b0;
    @(negedge clock);
    @(negedge clock);
    bin_in = 16'd777;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    wait_done(bn);
    repeat (25) @(negedge clock);
    check("ignored_no_extra", 32'(sb.size()), 32'd0);
    check("ignored_bcd_hold", 32'(bcd_out), 32'h00500);

    // Start held high: back-to-back conversions 17 cycles apart.
    @(negedge clock);
    c0     = cyc;
    bin_in = 16'd42;
    start  = 1'b1;
    sb.push_back('{bcd: 20'h00042, cyc: c0 + 17});
    @(negedge clock);
    bin_in = 16'd43;
    sb.push_back('{bcd: 20'h00043, cyc: c0 + 34});
    repeat (17) @(negedge clock);
    start = 1'b0;
    wait_done(bn);
    @(negedge clock);
    check("b2b_second_pending", 32'(sb.size()), 32'd0);

    // Reset mid-conversion abandons the result.
    do_conv(16'd99, 20'h00099);
    @(negedge clock);
    c0     = cyc;
    bin_in = 16'd300;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bcd", 32'(bcd_out), 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("midrst_no_done", 32'(sb.size()), 32'd0);
    do_conv(16'd300, 20'h00300);

    // Free-running counter source sampled at every acceptance.
    cnt16 = 16'hFF00;
    @(negedge clock);
    c0    = cyc;
    start = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      bin_in = cnt16;
      if (n % 17 == 0) sb.push_back('{bcd: to_bcd(int'(cnt16)), cyc: c0 + n + 17});
      cnt16 = cnt16 + 16'd1;
      @(negedge clock);
    end
    start = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
    check("counter_all_done", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm.
- Sits directly downstream of the 16-bit free-running counter: takes its 16-bit count and produces 5 packed BCD digits for the 7-segment display decoders.
- Uses a start/busy/done handshake, one bit per clock, so it needs no wide combinational adder chain.

Parameters:
- BIT_SZ, 16, width of binary input.
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^BIT_SZ - 1.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin_in  input  BIT_SZ  binary value; captured on the clock edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd_out has just been updated.
- bcd_out  output  4*DIGITS  packed BCD; [3:0] = units, [4*DIGITS-1:4*DIGITS-4] = most significant digit.

Behaviour:
- Reset (reset low, asynchronous, any state): state=IDLE, busy=0, done=0, bcd_out=0, internal shift/scratch registers and bit counter=0. A conversion in flight is abandoned; no done pulse is produced.
- States:
  - IDLE: busy=0. start=1 at edge k latches bin_in into the shift register, clears the BCD scratch, loads bit counter=BIT_SZ, and goes to SHIFT.
  - SHIFT: busy=1. At each edge, every scratch digit >=5 first gets +3 (4-bit add, no carry out). Then {scratch, shift} shifts left by 1, and the bit counter decrements.
  - SHIFT to IDLE: at the edge where the counter goes 1 to 0, the final shifted scratch is written to bcd_out, done is set to 1 and busy to 0, and state returns to IDLE.
- Latency: start accepted at edge k means iterations run at edges k+1..k+BIT_SZ. bcd_out and done are valid after edge k+BIT_SZ (16 cycles for defaults). done falls after edge k+BIT_SZ+1 unless re-set.
- start while busy=1 is ignored, with no queuing. bin_in changes while busy have no effect.
- start=1 in the cycle done=1 is accepted (state is IDLE). That gives back-to-back conversions with period BIT_SZ+1 cycles, and done pulses do not merge.
- bcd_out holds its last result between conversions and changes only on the completion edge, never mid-conversion.
- Width rules: scratch is 4*DIGITS bits. Max input 65535 gives 0x65535, so the top digit never exceeds 6 and there is no overflow. Each digit adjust is 4-bit: a value of 5..9 maps to 8..12.
- Digits in bcd_out are always 0..9.

Decomposition:
- Shared package bin2bcd_pkg:
  - BIT_SZ and DIGITS defaults.
  - State encoding constants (IDLE=1'b0, SHIFT=1'b1).
  - Bit-counter width, clog2(BIT_SZ+1).
- One sub-module, bcd_digit_adj: purely combinational 4-bit "add 3 if >=5". Instantiate it DIGITS times via generate.
- The FSM, shift register and counter stay in bin2bcd_seq.

Test Plan:
- Reset then bin_in=0, start pulse → done after exactly 16 cycles, bcd_out=0x00000, busy high for 16 cycles.
- bin_in=16'hFFFF (65535) → bcd_out=0x65535. bin_in=1234 → 0x01234. bin_in=9 → 0x00009. bin_in=10 → 0x00010.
- start at edge k with bin_in=500, then start pulses at k+3 with bin_in=777 → bcd_out=0x00500, single done at k+16, second request ignored.
- Back-to-back: start held high continuously, bin_in=42 then 43 → done pulses 17 cycles apart, bcd_out=0x00042 then 0x00043.
- Prior result 0x00099, then start with bin_in=300, reset low at cycle 8 → immediately busy=0, done=0, bcd_out=0x00000. After release, a new start with 300 → 0x00300.
- Drive from the counter_16 count output sampled every 17 cycles for 2000 cycles → bcd_out always matches the decimal value of the sampled count.
